gyro_adc_sampler: RTL and testbench

GYRO_ADC_SAMPLER -- requirements
Module: gyro_adc_sampler

---
 rtl/gyro_adc_sampler_if.sv | 27 ++
 rtl/gyro_adc_sampler.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_gyro_adc_sampler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gyro_adc_sampler_if.sv
// gyro_adc_sampler_if
// SPI bus between the gyro sampler (master) and the 8-channel 12-bit ADC
// (slave).
//   adc_cs_n  : chip select, active low
//   adc_sclk  : SPI clock, idles high
//   adc_din   : control word from the sampler to the ADC (MOSI)
//   adc_dout  : conversion data from the ADC to the sampler (MISO)
interface gyro_adc_sampler_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_din;
  logic adc_dout;

  modport master (
    output adc_cs_n,
    output adc_sclk,
    output adc_din,
    input  adc_dout
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sclk,
    input  adc_din,
    output adc_dout
  );
endinterface

// File: rtl/gyro_adc_sampler.sv
// gyro_adc_sampler
// Every SAMPLE_PERIOD clocks, runs a burst of four 16-clock SPI frames on a
// 12-bit ADC. The frames address CH_X, CH_Y, CH_Z and CH_Z. The ADC returns
// the conversion for the address sent in the previous frame. Frame 0 data is
// therefore thrown away, and frames 1..3 carry x, y and z.
//
// Ports:
//   clk, reset        : single clock; synchronous active-high reset
//   enable            : allows a period tick to start a new burst
//   adc               : SPI bus, master modport of gyro_adc_sampler_if
//   gyroscope_data_*  : raw 12-bit codes, zero-extended to 32 bits
//   data_valid        : one-cycle pulse when the three outputs load
//   busy              : burst in progress, including the data_valid cycle
//
// Build option: GYRO_ADC_SAMPLER_AVG_EN adds per-axis accumulators. With it,
// the outputs are the mean of four bursts and data_valid pulses on every
// fourth burst only.
module gyro_adc_sampler #(
  parameter int unsigned CLK_DIV       = 32'd8,
  parameter int unsigned SAMPLE_PERIOD = 32'd196078,
  parameter logic [2:0]  CH_X          = 3'd0,
  parameter logic [2:0]  CH_Y          = 3'd1,
  parameter logic [2:0]  CH_Z          = 3'd2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  gyro_adc_sampler_if.master adc,
  output logic [31:0]        gyroscope_data_x,
  output logic [31:0]        gyroscope_data_y,
  output logic [31:0]        gyroscope_data_z,
  output logic               data_valid,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0]  DIV_LAST    = 8'(CLK_DIV - 32'd1);
  localparam logic [31:0] PERIOD_LAST = 32'(SAMPLE_PERIOD - 32'd1);

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] timer_r;
  logic [7:0]  div_r;
  logic [4:0]  half_r;       // SCLK half-period index within SHIFT; even = low half
  logic [4:0]  half_next_s;
  logic [1:0]  frame_r;
  logic [11:0] shift_r;      // only 12 bits kept: the 4 leading bits fall off the top
  logic [11:0] x_cap_r;
  logic [11:0] y_cap_r;
  logic [11:0] z_cap_r;
  logic        tick_s;
  logic        start_s;
  logic        div_last_s;
  logic        sample_s;
  logic        capture_s;
  logic        load_s;
  logic [2:0]  addr_s;
  logic [15:0] word_s;
  logic [3:0]  bit_idx_s;
  logic        cs_n_next_s;
  logic        sclk_next_s;
  logic        din_next_s;
  logic        cs_n_r;
  logic        sclk_r;
  logic        din_r;

  assign adc.adc_cs_n = cs_n_r;
  assign adc.adc_sclk = sclk_r;
  assign adc.adc_din  = din_r;

  assign tick_s     = (timer_r == PERIOD_LAST);
  assign start_s    = tick_s && enable && (state_r == IDLE);
  assign div_last_s = (div_r == DIV_LAST);
  // The SCLK rising edge is the clock that ends an even (low) half-period.
  assign sample_s   = (state_r == SHIFT) && div_last_s && !half_r[0];
  assign capture_s  = (state_r == SHIFT) && (state_next_s == GAP);
  assign load_s     = (state_r == GAP) && (state_next_s == DONE);

  // Burst period timer; the wrap cycle is the tick
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 32'd0;
    end else if (tick_s) begin
      timer_r <= 32'd0;
    end else begin
      timer_r <= timer_r + 32'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_next_s = SETUP;
        else         state_next_s = IDLE;
      end
      SETUP: begin
        if (div_last_s) state_next_s = SHIFT;
        else            state_next_s = SETUP;
      end
      SHIFT: begin
        if (div_last_s && (half_r == 5'd31)) state_next_s = GAP;
        else                                 state_next_s = SHIFT;
      end
      GAP: begin
        if (div_last_s) begin
          if (frame_r != 2'd3) state_next_s = SETUP;
          else                 state_next_s = DONE;
        end else begin
          state_next_s = GAP;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Next values of the SPI pins. They are derived from the next state, so the
  // registered pins line up with the state they belong to.
  always_comb begin
    half_next_s = 5'd0;
    addr_s      = CH_Z;
    if (state_r == SHIFT) begin
      if (div_last_s) half_next_s = half_r + 5'd1;
      else            half_next_s = half_r;
    end else begin
      half_next_s = 5'd0;
    end
    case (frame_r)
      2'd0:    addr_s = CH_X;
      2'd1:    addr_s = CH_Y;
      2'd2:    addr_s = CH_Z;
      2'd3:    addr_s = CH_Z;
      default: addr_s = CH_Z;
    endcase
    word_s    = {2'b00, addr_s, 11'd0};
    // The bit index advances only when half goes odd->even, i.e. on SCLK fall.
    bit_idx_s = 4'd15 - half_next_s[4:1];
    cs_n_next_s = !((state_next_s == SETUP) || (state_next_s == SHIFT));
    if (state_next_s == SHIFT) begin
      sclk_next_s = half_next_s[0];
      din_next_s  = word_s[bit_idx_s];
    end else begin
      sclk_next_s = 1'b1;
      din_next_s  = 1'b0;
    end
  end

  // Clock divider, half-period and frame counters
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r   <= 8'd0;
      half_r  <= 5'd0;
      frame_r <= 2'd0;
    end else begin
      if (div_last_s || (state_r == IDLE) || (state_r == DONE)) begin
        div_r <= 8'd0;
      end else begin
        div_r <= div_r + 8'd1;
      end
      half_r <= half_next_s;
      if (state_r == IDLE) begin
        frame_r <= 2'd0;
      end else if ((state_r == GAP) && div_last_s) begin
        frame_r <= frame_r + 2'd1;
      end else begin
        frame_r <= frame_r;
      end
    end
  end

  // Registered SPI pins and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n_r <= 1'b1;
      sclk_r <= 1'b1;
      din_r  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      cs_n_r <= cs_n_next_s;
      sclk_r <= sclk_next_s;
      din_r  <= din_next_s;
      busy   <= (state_next_s != IDLE);
    end
  end

  // MISO shift register and per-frame capture (frame 0 is discarded)
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= 12'd0;
      x_cap_r <= 12'd0;
      y_cap_r <= 12'd0;
      z_cap_r <= 12'd0;
    end else begin
      if (sample_s) begin
        shift_r <= {shift_r[10:0], adc.adc_dout};
      end else begin
        shift_r <= shift_r;
      end
      if (capture_s) begin
        case (frame_r)
          2'd1:    x_cap_r <= shift_r;
          2'd2:    y_cap_r <= shift_r;
          2'd3:    z_cap_r <= shift_r;
          default: x_cap_r <= x_cap_r;
        endcase
      end else begin
        x_cap_r <= x_cap_r;
      end
    end
  end

`ifdef GYRO_ADC_SAMPLER_AVG_EN
  logic [13:0] acc_x_r;
  logic [13:0] acc_y_r;
  logic [13:0] acc_z_r;
  logic [1:0]  burst_cnt_r;
  logic [13:0] sum_x_s;
  logic [13:0] sum_y_s;
  logic [13:0] sum_z_s;

  assign sum_x_s = acc_x_r + {2'b00, x_cap_r};
  assign sum_y_s = acc_y_r + {2'b00, y_cap_r};
  assign sum_z_s = acc_z_r + {2'b00, z_cap_r};

  // Four-burst accumulation; every fourth burst publishes sum/4 and clears
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x_r          <= 14'd0;
      acc_y_r          <= 14'd0;
      acc_z_r          <= 14'd0;
      burst_cnt_r      <= 2'd0;
      gyroscope_data_x <= 32'd0;
      gyroscope_data_y <= 32'd0;
      gyroscope_data_z <= 32'd0;
      data_valid       <= 1'b0;
    end else if (load_s && (burst_cnt_r == 2'd3)) begin
      acc_x_r          <= 14'd0;
      acc_y_r          <= 14'd0;
      acc_z_r          <= 14'd0;
      burst_cnt_r      <= 2'd0;
      gyroscope_data_x <= {20'd0, sum_x_s[13:2]};
      gyroscope_data_y <= {20'd0, sum_y_s[13:2]};
      gyroscope_data_z <= {20'd0, sum_z_s[13:2]};
      data_valid       <= 1'b1;
    end else if (load_s) begin
      acc_x_r     <= sum_x_s;
      acc_y_r     <= sum_y_s;
      acc_z_r     <= sum_z_s;
      burst_cnt_r <= burst_cnt_r + 2'd1;
      data_valid  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
    end
  end
`else
  // Every burst publishes its three codes and pulses data_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      gyroscope_data_x <= 32'd0;
      gyroscope_data_y <= 32'd0;
      gyroscope_data_z <= 32'd0;
      data_valid       <= 1'b0;
    end else if (load_s) begin
      gyroscope_data_x <= {20'd0, x_cap_r};
      gyroscope_data_y <= {20'd0, y_cap_r};
      gyroscope_data_z <= {20'd0, z_cap_r};
      data_valid       <= 1'b1;
    end else begin
      data_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_gyro_adc_sampler.sv
// Bench for gyro_adc_sampler with a behavioural 12-bit SPI ADC model.
// The model decodes the address of each frame and, in the next frame,
// returns the code programmed for that address. Expected outputs go into a
// scoreboard queue when the codes are programmed. Entries are popped when
// data_valid pulses.
module tb_gyro_adc_sampler;
  localparam int unsigned CLK_DIV       = 32'd4;
  localparam int unsigned SAMPLE_PERIOD = 32'd1000;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] gx;
  logic [31:0] gy;
  logic [31:0] gz;
  logic        dv;
  logic        busy;

  gyro_adc_sampler_if adc_bus();

  gyro_adc_sampler #(
    .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .CH_X(3'd0), .CH_Y(3'd1), .CH_Z(3'd2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc(adc_bus),
    .gyroscope_data_x(gx), .gyroscope_data_y(gy), .gyroscope_data_z(gz),
    .data_valid(dv), .busy(busy)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // clock edge counter, read only on negedges
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ADC programming and scoreboard
  logic [11:0] code_x = 12'h000;
  logic [11:0] code_y = 12'h000;
  logic [11:0] code_z = 12'h000;
  logic [3:0]  lead_bits = 4'h0;
  logic [95:0] sb_q[$];

  function automatic logic [11:0] code_for(input logic [2:0] a);
    case (a)
      3'd0:    return code_x;
      3'd1:    return code_y;
      3'd2:    return code_z;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [2:0] exp_addr(input int f);
    case (f)
      0:       return 3'd0;
      1:       return 3'd1;
      2:       return 3'd2;
      3:       return 3'd2;
      default: return 3'd7;
    endcase
  endfunction

  // monitor / ADC model state
  logic        prev_cs_n = 1'b1;
  logic        prev_sclk = 1'b1;
  logic        prev_din  = 1'b0;
  logic [15:0] rx        = 16'd0;
  logic [15:0] tx_word   = 16'd0;
  logic [2:0]  last_addr = 3'd0;
  int          tx_idx    = 15;
  int          rise_cnt  = 0;
  int          low_width = 0;
  int          frame_idx = 0;
  int          din_viol  = 0;
  int          dv_cnt    = 0;
  int          n_starts  = 0;
  int          start_cyc = 0;
  logic        dv_low_pending = 1'b0;

  initial begin
    logic [95:0] e;
    adc_bus.adc_dout = 1'b0;
    forever begin
      @(negedge clk);
      if (dv_low_pending) begin
        check_value("dv_one_cycle", 32'(dv), 32'd0);
        dv_low_pending = 1'b0;
      end
      if (dv) begin
        dv_cnt++;
        dv_low_pending = 1'b1;
        check_value("busy_at_dv", 32'(busy), 32'd1);
        check_value("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_value("data_x", gx, e[95:64]);
          check_value("data_y", gy, e[63:32]);
          check_value("data_z", gz, e[31:0]);
        end
      end
      if (reset) begin
        frame_idx = 0;
        rise_cnt  = 0;
      end else begin
        if (!busy) frame_idx = 0;
        if (prev_cs_n && !adc_bus.adc_cs_n) begin
          low_width = 0;
          rise_cnt  = 0;
          rx        = 16'd0;
          if (frame_idx == 0) begin
            start_cyc = cyc;
            n_starts++;
          end
          tx_word = {lead_bits, code_for(last_addr)};
          tx_idx  = 15;
        end
        if (!adc_bus.adc_cs_n) low_width++;
        if (!adc_bus.adc_cs_n && prev_sclk && !adc_bus.adc_sclk) begin
          adc_bus.adc_dout = tx_word[tx_idx];
          if (tx_idx > 0) tx_idx--;
        end
        if (!adc_bus.adc_cs_n && !prev_sclk && adc_bus.adc_sclk) begin
          rx = {rx[14:0], adc_bus.adc_din};
          rise_cnt++;
        end
        if ((adc_bus.adc_din != prev_din) && !(prev_sclk && !adc_bus.adc_sclk)) din_viol++;
        if (!prev_cs_n && adc_bus.adc_cs_n) begin
          check_value("cs_low_width", 32'(low_width), 32'd132);
          check_value("sclk_rises", 32'(rise_cnt), 32'd16);
          check_value("frame_addr", 32'(rx[13:11]), 32'(exp_addr(frame_idx)));
          check_value("word_zero_bits", 32'({rx[15:14], rx[10:0]}), 32'd0);
          last_addr = rx[13:11];
          frame_idx++;
        end
      end
      prev_cs_n = adc_bus.adc_cs_n;
      prev_sclk = adc_bus.adc_sclk;
      prev_din  = adc_bus.adc_din;
    end
  end

  task automatic wait_start(input string tag, input int max_cyc);
    int n0 = n_starts;
    int n  = 0;
    while ((n_starts == n0) && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, 32'(n_starts != n0), 32'd1);
  endtask

  task automatic wait_dv(input string tag, input int max_cyc);
    int d0 = dv_cnt;
    int n  = 0;
    while ((dv_cnt == d0) && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, 32'(dv_cnt != d0), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (busy && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, 32'(busy), 32'd0);
  endtask

  task automatic program_codes(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z,
                               input logic [3:0] lead, input bit expect_out);
    code_x    = x;
    code_y    = y;
    code_z    = z;
    lead_bits = lead;
    if (expect_out) sb_q.push_back({20'd0, x, 20'd0, y, 20'd0, z});
  endtask

  initial begin
    int rel_cyc;
    int s;
    int d0;
    repeat (5) @(negedge clk);
    check_value("rst_cs_n", 32'(adc_bus.adc_cs_n), 32'd1);
    check_value("rst_sclk", 32'(adc_bus.adc_sclk), 32'd1);
    check_value("rst_din", 32'(adc_bus.adc_din), 32'd0);
    check_value("rst_x", gx, 32'd0);
    check_value("rst_y", gy, 32'd0);
    check_value("rst_z", gz, 32'd0);
    check_value("rst_dv", 32'(dv), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);

`ifdef GYRO_ADC_SAMPLER_AVG_EN
    d0 = dv_cnt;
    for (int b = 0; b < 4; b++) begin
      program_codes(12'h123, 12'h456, 12'(100 + b), 4'h0, 1'b0);
      if (b == 3) sb_q.push_back({32'h123, 32'h456, 32'd101});
      if (b == 0) begin
        reset   = 1'b0;
        rel_cyc = cyc;
      end
      wait_start("avg_start", 1100);
      if (b == 0) check_value("first_tick", 32'(start_cyc - rel_cyc), 32'd1000);
      wait_idle("avg_burst_end", 700);
      if (b < 3) check_value("avg_no_dv", 32'(dv_cnt), 32'(d0));
      else       check_value("avg_one_dv", 32'(dv_cnt), 32'(d0 + 1));
    end
`else
    // basic burst with first-tick timing
    program_codes(12'h123, 12'h456, 12'h789, 4'h0, 1'b1);
    reset   = 1'b0;
    rel_cyc = cyc;
    wait_start("first_start", 1100);
    check_value("first_tick", 32'(start_cyc - rel_cyc), 32'd1000);
    wait_dv("dv_basic", 700);

    // leading bits set, full-scale code
    program_codes(12'hFFF, 12'hFFF, 12'hFFF, 4'hF, 1'b1);
    wait_dv("dv_fullscale", 1100);
    check_value("no_upper_bits", gx >> 12, 32'd0);

    // mixed patterns with noisy leading bits
    program_codes(12'h000, 12'hA5A, 12'h5A5, 4'h5, 1'b1);
    wait_dv("dv_mixed", 1100);

    // enable dropped mid-burst, then one masked tick
    program_codes(12'h321, 12'h654, 12'h987, 4'h0, 1'b1);
    wait_start("start_en", 1100);
    s = start_cyc;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    wait_dv("dv_en_drop", 700);
    while (cyc < s + 1200) @(negedge clk);
    enable = 1'b1;
    program_codes(12'h0F0, 12'h00F, 12'hF00, 4'h0, 1'b1);
    wait_start("start_after_mask", 1100);
    check_value("masked_interval", 32'(start_cyc - s), 32'd2000);
    wait_dv("dv_after_mask", 700);

    // reset at clock 50 of frame 2
    program_codes(12'h111, 12'h222, 12'h333, 4'h0, 1'b0);
    wait_start("start_abort", 1100);
    s = start_cyc;
    d0 = dv_cnt;
    while (cyc < s + 322) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_value("abort_cs_n", 32'(adc_bus.adc_cs_n), 32'd1);
    check_value("abort_sclk", 32'(adc_bus.adc_sclk), 32'd1);
    check_value("abort_din", 32'(adc_bus.adc_din), 32'd0);
    check_value("abort_x", gx, 32'd0);
    check_value("abort_y", gy, 32'd0);
    check_value("abort_z", gz, 32'd0);
    check_value("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    rel_cyc = cyc;
    program_codes(12'h246, 12'h8AC, 12'hE02, 4'h0, 1'b1);
    wait_start("start_post_rst", 1100);
    check_value("post_rst_tick", 32'(start_cyc - rel_cyc), 32'd1000);
    wait_dv("dv_post_rst", 700);
    check_value("no_dv_aborted", 32'(dv_cnt), 32'(d0 + 1));
`endif

    repeat (3) @(negedge clk);
    check_value("din_stable", 32'(din_viol), 32'd0);
    check_value("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
